// File: rtl/instr_enc.sv
// instr_enc - MSP430 instruction encoder.
//
// Takes one decoded instruction as fields and emits its 1-3 word machine
// encoding (opcode word, then the source and destination extension words
// when the addressing modes need them), one word per word_valid/word_ready
// handshake.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   in_valid / in_ready  request handshake for the field inputs
//   fmt, op, reg_SA, reg_DA, As, Ad, BW, src_ext, dst_ext, jmp_off
//                        decoded instruction fields, latched on accept
//   MDB_in, word_valid / word_ready
//                        encoded output word and its handshake
//   word_first, word_last, instr_len
//                        position of the current word and the total word count
//   err                  one-cycle pulse after an illegal request was dropped
module instr_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [3:0]  op,
    input  logic [3:0]  reg_SA,
    input  logic [3:0]  reg_DA,
    input  logic [1:0]  As,
    input  logic        Ad,
    input  logic        BW,
    input  logic [15:0] src_ext,
    input  logic [15:0] dst_ext,
    input  logic [9:0]  jmp_off,
    output logic [15:0] MDB_in,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_first,
    output logic        word_last,
    output logic [1:0]  instr_len,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OPW  = 2'd1;
    localparam logic [1:0] SRCW = 2'd2;
    localparam logic [1:0] DSTW = 2'd3;

    logic [1:0]  state_r;
    logic [15:0] mdb_r;
    logic        valid_r;
    logic        first_r;
    logic        last_r;
    logic [1:0]  len_r;
    logic        err_r;
    logic        in_ready_r;
    logic [15:0] src_ext_r;
    logic [15:0] dst_ext_r;
    logic        src_need_r;

    logic [15:0] opword_s;
    logic        src_need_s;
    logic        dst_need_s;
    logic        illegal_s;
    logic        src_mode_s;
    logic [1:0]  len_s;
    logic        accept_s;
    logic        handshake_s;

    // Indexed/symbolic/absolute (As=01, not R3) and immediate (@PC+) carry a
    // source extension word; the constant-generator encodings never do.
    assign src_mode_s  = ((As == 2'b01) && (reg_SA != 4'd3)) ||
                         ((As == 2'b11) && (reg_SA == 4'd0));
    assign len_s       = 2'd1 + {1'b0, src_need_s} + {1'b0, dst_need_s};
    assign accept_s    = in_valid && in_ready_r;
    assign handshake_s = valid_r && word_ready;

    // Decode the live request fields into opcode word, extension needs and legality.
    always_comb begin
        opword_s   = 16'h0000;
        src_need_s = 1'b0;
        dst_need_s = 1'b0;
        illegal_s  = 1'b0;
        case (fmt)
            2'd1: begin
                if (op < 4'd4) begin
                    illegal_s = 1'b1;
                end else begin
                    opword_s   = {op, reg_SA, Ad, BW, As, reg_DA};
                    src_need_s = src_mode_s;
                    dst_need_s = Ad;
                end
            end
            2'd2: begin
                if (op[2:0] == 3'd7) begin
                    illegal_s = 1'b1;
                end else if (op[2:0] == 3'd6) begin
                    // RETI has a fixed encoding regardless of the other fields.
                    opword_s = 16'h1300;
                end else begin
                    opword_s   = {6'b000100, op[2:0], BW, As, reg_SA};
                    src_need_s = src_mode_s;
                end
            end
            2'd3: begin
                opword_s = {3'b001, op[2:0], jmp_off};
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Request capture, word sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mdb_r      <= 16'h0000;
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            len_r      <= 2'd0;
            err_r      <= 1'b0;
            in_ready_r <= 1'b0;
            src_ext_r  <= 16'h0000;
            dst_ext_r  <= 16'h0000;
            src_need_r <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && !illegal_s) begin
                        state_r    <= OPW;
                        in_ready_r <= 1'b0;
                        valid_r    <= 1'b1;
                        first_r    <= 1'b1;
                        last_r     <= (len_s == 2'd1);
                        len_r      <= len_s;
                        mdb_r      <= opword_s;
                        src_ext_r  <= src_ext;
                        dst_ext_r  <= dst_ext;
                        src_need_r <= src_need_s;
                    end else begin
                        // Illegal requests are swallowed here; stay ready.
                        err_r      <= accept_s;
                        in_ready_r <= 1'b1;
                    end
                end
                OPW, SRCW, DSTW: begin
                    if (handshake_s && last_r) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        valid_r    <= 1'b0;
                        first_r    <= 1'b0;
                        last_r     <= 1'b0;
                        len_r      <= 2'd0;
                        mdb_r      <= 16'h0000;
                    end else if (handshake_s) begin
                        first_r <= 1'b0;
                        // Not the last word, so a destination word always follows SRCW,
                        // and OPW goes to SRCW only when a source word exists.
                        if ((state_r == OPW) && src_need_r) begin
                            state_r <= SRCW;
                            mdb_r   <= src_ext_r;
                            last_r  <= (len_r == 2'd2);
                        end else begin
                            state_r <= DSTW;
                            mdb_r   <= dst_ext_r;
                            last_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                    valid_r    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign MDB_in     = mdb_r;
    assign word_valid = valid_r;
    assign word_first = first_r;
    assign word_last  = last_r;
    assign instr_len  = len_r;
    assign err        = err_r;

endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc - self-checking bench for instr_enc: directed vector table,
// backpressure and mid-instruction reset sequences, then randomized requests
// compared against an arithmetic reference model.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = 2'd0;
    logic [3:0]  op = 4'd0;
    logic [3:0]  reg_SA = 4'd0;
    logic [3:0]  reg_DA = 4'd0;
    logic [1:0]  As = 2'd0;
    logic        Ad = 1'b0;
    logic        BW = 1'b0;
    logic [15:0] src_ext = 16'h0000;
    logic [15:0] dst_ext = 16'h0000;
    logic [9:0]  jmp_off = 10'd0;
    logic [15:0] MDB_in;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        word_first;
    logic        word_last;
    logic [1:0]  instr_len;
    logic        err;

    int checks = 0;
    int errors = 0;

    instr_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .reg_SA(reg_SA), .reg_DA(reg_DA), .As(As), .Ad(Ad),
        .BW(BW), .src_ext(src_ext), .dst_ext(dst_ext), .jmp_off(jmp_off),
        .MDB_in(MDB_in), .word_valid(word_valid), .word_ready(word_ready),
        .word_first(word_first), .word_last(word_last), .instr_len(instr_len),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [1:0]  as_m;
        logic        ad;
        logic        bw;
        logic [15:0] sext;
        logic [15:0] dext;
        logic [9:0]  joff;
        logic        illegal;
        int          len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int f, input int o, input int sa, input int da,
                                input int as_m, input int ad, input int bw,
                                input int sext, input int dext, input int joff,
                                input int ill, input int len,
                                input int w0, input int w1, input int w2);
        vec_t v;
        v.fmt = f[1:0];  v.op = o[3:0];  v.sa = sa[3:0];  v.da = da[3:0];
        v.as_m = as_m[1:0];  v.ad = ad[0];  v.bw = bw[0];
        v.sext = sext[15:0];  v.dext = dext[15:0];  v.joff = joff[9:0];
        v.illegal = ill[0];  v.len = len;
        v.w0 = w0[15:0];  v.w1 = w1[15:0];  v.w2 = w2[15:0];
        return v;
    endfunction

    // Reference: builds the word list straight from the encoding rules.
    function automatic vec_t model(input vec_t r);
        vec_t v;
        logic [15:0] q[$];
        int f, o, sa, da, am, ad, bw, w;
        bit src, reti;
        v = r;
        f = int'(r.fmt); o = int'(r.op); sa = int'(r.sa); da = int'(r.da);
        am = int'(r.as_m); ad = int'(r.ad); bw = int'(r.bw);
        reti = (f == 2) && (o % 8 == 6);
        v.illegal = (f == 0) || (f == 1 && o < 4) || (f == 2 && o % 8 == 7);
        src = (f == 1 || (f == 2 && !reti)) &&
              ((am == 1 && sa != 3) || (am == 3 && sa == 0));
        w = 0;
        if (f == 1) w = o * 4096 + sa * 256 + ad * 128 + bw * 64 + am * 16 + da;
        else if (f == 2 && reti) w = 'h1300;
        else if (f == 2) w = 'h1000 + (o % 8) * 128 + bw * 64 + am * 16 + sa;
        else if (f == 3) w = 'h2000 + (o % 8) * 1024 + int'(r.joff);
        q.push_back(w[15:0]);
        if (src) q.push_back(r.sext);
        if (f == 1 && ad == 1) q.push_back(r.dext);
        v.len = v.illegal ? 0 : q.size();
        v.w0 = q[0];
        v.w1 = (q.size() > 1) ? q[1] : 16'h0000;
        v.w2 = (q.size() > 2) ? q[2] : 16'h0000;
        return v;
    endfunction

    task automatic apply_fields(input vec_t v);
        fmt = v.fmt; op = v.op; reg_SA = v.sa; reg_DA = v.da; As = v.as_m;
        Ad = v.ad; BW = v.bw; src_ext = v.sext; dst_ext = v.dext; jmp_off = v.joff;
    endtask

    task automatic scramble_fields();
        fmt = 2'($urandom); op = 4'($urandom); reg_SA = 4'($urandom);
        reg_DA = 4'($urandom); As = 2'($urandom); Ad = 1'($urandom);
        BW = 1'($urandom); src_ext = 16'($urandom); dst_ext = 16'($urandom);
        jmp_off = 10'($urandom);
    endtask

    // bp_mode: 0 = always ready, 1 = random stalls, 2 = 3-cycle stall on word 2.
    task automatic do_req(input vec_t v, input int bp_mode);
        int k, waited, stalls;
        logic [15:0] ew;
        logic r;
        @(negedge clk);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        apply_fields(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble_fields();
        if (v.illegal) begin
            check("err_pulse", {31'd0, err}, 32'd1);
            check("illegal_no_word", {31'd0, word_valid}, 32'd0);
            check("illegal_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            check("err_clear", {31'd0, err}, 32'd0);
            check("illegal_no_word2", {31'd0, word_valid}, 32'd0);
        end else begin
            k = 0; stalls = 0; waited = 0;
            while (k < v.len && waited < 40) begin
                ew = (k == 0) ? v.w0 : ((k == 1) ? v.w1 : v.w2);
                check("word_valid", {31'd0, word_valid}, 32'd1);
                check("mdb_in", {16'd0, MDB_in}, {16'd0, ew});
                check("word_first", {31'd0, word_first}, (k == 0) ? 32'd1 : 32'd0);
                check("word_last", {31'd0, word_last}, (k == v.len - 1) ? 32'd1 : 32'd0);
                check("instr_len", {30'd0, instr_len}, v.len);
                check("busy_in_ready", {31'd0, in_ready}, 32'd0);
                check("busy_err", {31'd0, err}, 32'd0);
                if (bp_mode == 1) r = (stalls < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
                else if (bp_mode == 2) r = (k == 1 && stalls < 3) ? 1'b0 : 1'b1;
                else r = 1'b1;
                word_ready = r;
                @(negedge clk);
                waited++;
                if (r) begin
                    k++;
                    stalls = 0;
                end else begin
                    stalls++;
                end
            end
            word_ready = 1'b0;
            check("words_done", k, v.len);
            check("end_word_valid", {31'd0, word_valid}, 32'd0);
            check("end_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    vec_t tbl[15];
    vec_t add_v;
    vec_t rv;

    initial begin
        tbl[0]  = mk(1, 4, 5, 6, 0, 0, 0, 'h0000, 'h0000, 0,     0, 1, 'h4506, 0, 0);
        tbl[1]  = mk(1, 5, 0, 2, 3, 1, 0, 'h1234, 'h0200, 0,     0, 3, 'h50B2, 'h1234, 'h0200);
        tbl[2]  = mk(1, 4, 2, 4, 3, 0, 0, 'hAAAA, 'hBBBB, 0,     0, 1, 'h4234, 0, 0);
        tbl[3]  = mk(2, 4, 5, 0, 0, 0, 0, 'h1111, 'h2222, 0,     0, 1, 'h1205, 0, 0);
        tbl[4]  = mk(2, 6, 5, 9, 1, 1, 1, 'h3333, 'h4444, 'h155, 0, 1, 'h1300, 0, 0);
        tbl[5]  = mk(3, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000, 'h3FE, 0, 1, 'h23FE, 0, 0);
        tbl[6]  = mk(0, 4, 5, 6, 0, 0, 0, 'h0000, 'h0000, 0,     1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 3, 5, 6, 1, 1, 0, 'h5555, 'h6666, 0,     1, 0, 0, 0, 0);
        tbl[8]  = mk(2, 7, 0, 0, 3, 0, 0, 'h7777, 'h8888, 0,     1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 4, 4, 5, 1, 0, 0, 'h0002, 'h9999, 0,     0, 2, 'h4415, 'h0002, 0);
        tbl[10] = mk(1, 4, 3, 5, 1, 0, 0, 'hCCCC, 'hDDDD, 0,     0, 1, 'h4315, 0, 0);
        tbl[11] = mk(2, 5, 0, 0, 3, 0, 0, 'h4400, 'hEEEE, 0,     0, 2, 'h12B0, 'h4400, 0);
        tbl[12] = mk(1, 4, 7, 2, 0, 1, 1, 'h0000, 'h0210, 0,     0, 2, 'h47C2, 'h0210, 0);
        tbl[13] = mk(1, 4, 2, 6, 1, 0, 0, 'h0300, 'h0000, 0,     0, 2, 'h4216, 'h0300, 0);
        tbl[14] = mk(3, 7, 0, 0, 0, 0, 0, 'h0000, 'h0000, 'h001, 0, 1, 'h3C01, 0, 0);
        add_v = tbl[1];

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mdb", {16'd0, MDB_in}, 32'd0);
        check("rst_len", {30'd0, instr_len}, 32'd0);
        check("rst_flags", {29'd0, word_first, word_last, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) do_req(tbl[i], 0);

        // Backpressure on the source extension word.
        do_req(add_v, 2);

        // Reset while the destination word is pending.
        @(negedge clk);
        apply_fields(add_v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(negedge clk);
        word_ready = 1'b0;
        check("rst_mid_dstw", {16'd0, MDB_in}, 32'h0200);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, word_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_after", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_words", {31'd0, word_valid}, 32'd0);
            @(negedge clk);
        end
        word_ready = 1'b0;

        // Randomized requests against the reference model.
        for (int i = 0; i < 120; i++) begin
            rv.fmt = 2'($urandom); rv.op = 4'($urandom); rv.sa = 4'($urandom);
            rv.da = 4'($urandom); rv.as_m = 2'($urandom); rv.ad = 1'($urandom);
            rv.bw = 1'($urandom); rv.sext = 16'($urandom); rv.dext = 16'($urandom);
            rv.joff = 10'($urandom);
            rv = model(rv);
            do_req(rv, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
